oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
Parameters:
REQ-001 CYCLES_PER_BYTE, 4, clocks per copied byte (one M-cycle); legal range 2..15.
REQ-002 START_DELAY, 4, clocks between the FF46 write and the first source read; legal range 1..15.
Ports (name, direction, width, meaning):
REQ-003 clk  in  1  single system clock; all logic on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 mmio_a  in  16  CPU register address.
REQ-006 mmio_din  in  8  CPU write data.
REQ-007 mmio_wr  in  1  CPU write strobe.
REQ-008 mmio_dout  out  8  CPU read data for FF46.
REQ-009 bus_a  out  16  source memory address.
REQ-010 bus_rd  out  1  source read strobe; data is returned on bus_din one clock later.
REQ-011 bus_din  in  8  source read data.
REQ-012 oam_a  out  16  OAM write address.
REQ-013 oam_din  out  8  OAM write data.
REQ-014 oam_wr  out  1  OAM write strobe.
REQ-015 dma_active  out  1  high while a transfer is pending or running; the CPU bus arbiter uses it.

Function
REQ-016 The block SHALL hold an 8-bit DMA register, loaded on any clock with mmio_wr=1 and mmio_a=16'hFF46.
REQ-017 mmio_dout SHALL be the DMA register when mmio_a=16'hFF46 and mmio_wr=0, and 0 otherwise; this path is combinational.
REQ-018 The FSM SHALL have three states: DMA_IDLE, DMA_DELAY and DMA_XFER.
REQ-019 An FF46 write in any state SHALL enter DMA_DELAY on the next clock. It SHALL clear the byte index and delay counter, and latch the source high byte.
REQ-020 The source high byte SHALL be mmio_din, or mmio_din-8'h20 when mmio_din>=8'hE0 (echo RAM mapping).
REQ-021 DMA_DELAY SHALL last START_DELAY clocks and then enter DMA_XFER with index 0 and phase 0.
REQ-022 In DMA_XFER, a phase counter SHALL run 0..CYCLES_PER_BYTE-1 for each byte.
REQ-023 At phase 0 the block SHALL drive bus_rd=1 and bus_a={src_hi, index}.
REQ-024 At phase 1 the block SHALL drive oam_wr=1, oam_a=16'hFE00+index and oam_din=bus_din.
REQ-025 At phase CYCLES_PER_BYTE-1 the index SHALL increment. After index 159 (8'h9F) completes, the FSM SHALL return to DMA_IDLE.
REQ-026 One transfer SHALL take exactly START_DELAY+160*CYCLES_PER_BYTE clocks of dma_active=1, which is 644 clocks at the defaults.
REQ-027 Whenever bus_rd=0, bus_a SHALL be 16'hFFFF. Whenever oam_wr=0, oam_a SHALL be 16'hFFFF and oam_din SHALL be 0.
REQ-028 dma_active SHALL be 1 in DMA_DELAY and DMA_XFER, and 0 in DMA_IDLE.
REQ-029 A restart write that lands on the same clock as a phase-1 write SHALL still perform that OAM write. No later write of the old transfer SHALL occur.
REQ-030 The index SHALL be 8 bits wide and SHALL never exceed 159. The block SHALL generate no address outside FE00..FE9F.
REQ-031 Writes to any address other than FF46 SHALL have no effect on the block.

Reset
REQ-032 While rst_n=0, the block SHALL immediately force the following, independent of clk: state=DMA_IDLE, DMA register=0, index=0, phase=0, dma_active=0, bus_rd=0, oam_wr=0, bus_a=oam_a=16'hFFFF, oam_din=0.
REQ-033 Reset deassertion SHALL be synchronised before it reaches the FSM, so the first active edge is clean. A transfer cut off by reset SHALL NOT resume.

Structure
REQ-034 The shared package ppu_pkg SHALL hold the type and constants: typedef dma_state_t {DMA_IDLE, DMA_DELAY, DMA_XFER}, OAM_BASE=16'hFE00, OAM_BYTES=160, DMA_REG_ADDR=16'hFF46.
REQ-035 The block SHALL be a single module with no sub-modules. The OAM write port SHALL be muxed with the OAM-search read port at the PPU top level, with DMA taking priority.

Verification
REQ-036 Write 8'hC0 to FF46 with a memory model of C000+i=i^8'h5A -> OAM FE00+i holds i^8'h5A for i=0..159; dma_active is high for exactly 644 clocks; exactly 160 oam_wr pulses occur.
REQ-037 Write 8'hC0, then write 8'hC1 after the 50th oam_wr -> the next read is C100 after 4 delay clocks; 210 oam_wr pulses occur in total; FE00..FE9F end holding the C100 data.
REQ-038 Write 8'hE3 -> bus_a sequence runs C300..C39F; a read of FF46 returns 8'hE3.
REQ-039 Assert rst_n=0 mid-clock after the 10th oam_wr -> oam_wr, bus_rd and dma_active drop without waiting for a clock edge; no writes occur after release; FF46 reads 0.
REQ-040 With CYCLES_PER_BYTE=2 and START_DELAY=1 -> the transfer lasts 321 clocks; oam_wr is asserted every other clock.
REQ-041 Write 8'hC0 to FF45 and FF47 -> dma_active stays 0; bus_rd and oam_wr stay 0.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU types and constants: DMA FSM states, OAM window and DMA register address.
package ppu_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_DELAY = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] OAM_BASE      = 16'hFE00;
  localparam logic [7:0]  OAM_BYTES     = 8'd160;
  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
  localparam logic [7:0]  ECHO_PAGE_MIN = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET   = 8'h20;

  // Echo RAM (E000-FDFF) mirrors C000-DDFF, so the DMA source page is folded down.
  function automatic logic [7:0] dma_src_page(input logic [7:0] page);
    logic [7:0] res;
    if (page >= ECHO_PAGE_MIN) begin
      res = page - ECHO_OFFSET;
    end else begin
      res = page;
    end
    return res;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to FF46 copies 160 bytes from {page,00..9F} into FE00..FE9F,
// one byte every CYCLES_PER_BYTE clocks after a START_DELAY-clock start-up delay.
module oam_dma
  import ppu_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mmio_a,
  input  logic [7:0]  mmio_din,
  input  logic        mmio_wr,
  output logic [7:0]  mmio_dout,
  output logic [15:0] bus_a,
  output logic        bus_rd,
  input  logic [7:0]  bus_din,
  output logic [15:0] oam_a,
  output logic [7:0]  oam_din,
  output logic        oam_wr,
  output logic        dma_active
);

  localparam logic [3:0] PHASE_LAST = 4'(CYCLES_PER_BYTE - 1);
  localparam logic [3:0] DELAY_LAST = 4'(START_DELAY - 1);
  localparam logic [7:0] INDEX_LAST = OAM_BYTES - 8'd1;

  logic [1:0] rst_sync_q;
  logic       rst_fsm_n;

  dma_state_t state_q,   state_d;
  logic [7:0] dma_reg_q, dma_reg_d;
  logic [7:0] src_hi_q,  src_hi_d;
  logic [7:0] index_q,   index_d;
  logic [3:0] phase_q,   phase_d;
  logic [3:0] delay_q,   delay_d;

  logic reg_wr_s;
  logic xfer_s;

  // Reset synchroniser: asserts asynchronously, releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_fsm_n = rst_sync_q[1];
  assign reg_wr_s  = mmio_wr && (mmio_a == DMA_REG_ADDR);
  assign xfer_s    = (state_q == DMA_XFER);

  // State and datapath registers; a reset mid-transfer discards the transfer entirely.
  always_ff @(posedge clk or negedge rst_fsm_n) begin
    if (!rst_fsm_n) begin
      state_q   <= DMA_IDLE;
      dma_reg_q <= 8'h00;
      src_hi_q  <= 8'h00;
      index_q   <= 8'h00;
      phase_q   <= 4'h0;
      delay_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      dma_reg_q <= dma_reg_d;
      src_hi_q  <= src_hi_d;
      index_q   <= index_d;
      phase_q   <= phase_d;
      delay_q   <= delay_d;
    end
  end

  // Next-state logic: an FF46 write restarts from any state, otherwise sequence delay then copy.
  always_comb begin
    state_d   = state_q;
    dma_reg_d = dma_reg_q;
    src_hi_d  = src_hi_q;
    index_d   = index_q;
    phase_d   = phase_q;
    delay_d   = delay_q;
    if (reg_wr_s) begin
      dma_reg_d = mmio_din;
      src_hi_d  = dma_src_page(mmio_din);
      state_d   = DMA_DELAY;
      index_d   = 8'h00;
      phase_d   = 4'h0;
      delay_d   = 4'h0;
    end else begin
      case (state_q)
        DMA_IDLE: begin
          state_d = DMA_IDLE;
        end
        DMA_DELAY: begin
          if (delay_q == DELAY_LAST) begin
            state_d = DMA_XFER;
            index_d = 8'h00;
            phase_d = 4'h0;
            delay_d = 4'h0;
          end else begin
            delay_d = delay_q + 4'h1;
          end
        end
        DMA_XFER: begin
          if (phase_q == PHASE_LAST) begin
            phase_d = 4'h0;
            if (index_q == INDEX_LAST) begin
              state_d = DMA_IDLE;
              index_d = 8'h00;
            end else begin
              index_d = index_q + 8'h01;
            end
          end else begin
            phase_d = phase_q + 4'h1;
          end
        end
        default: begin
          state_d = DMA_IDLE;
          index_d = 8'h00;
          phase_d = 4'h0;
          delay_d = 4'h0;
        end
      endcase
    end
  end

  // Bus/OAM strobes decode straight from the registered phase; idle buses park at FFFF / 00.
  always_comb begin
    bus_rd     = xfer_s && (phase_q == 4'h0);
    oam_wr     = xfer_s && (phase_q == 4'h1);
    dma_active = (state_q != DMA_IDLE);
    if (bus_rd) begin
      bus_a = {src_hi_q, index_q};
    end else begin
      bus_a = 16'hFFFF;
    end
    if (oam_wr) begin
      oam_a   = OAM_BASE + {8'h00, index_q};
      oam_din = bus_din;
    end else begin
      oam_a   = 16'hFFFF;
      oam_din = 8'h00;
    end
  end

  // CPU read-back of the DMA register; only visible on a read cycle addressed to FF46.
  always_comb begin
    if ((mmio_a == DMA_REG_ADDR) && !mmio_wr) begin
      mmio_dout = dma_reg_q;
    end else begin
      mmio_dout = 8'h00;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: source memory model plus read/write scoreboards.
module tb_oam_dma;

  logic        clk;
  logic        rst_n;
  logic [15:0] mmio_a;
  logic [7:0]  mmio_din;
  logic        mmio_wr;
  logic        mmio_wr2;
  logic [7:0]  mmio_dout, mmio_dout2;
  logic [15:0] bus_a, bus_a2;
  logic        bus_rd, bus_rd2;
  logic [7:0]  bus_din, bus_din2;
  logic [15:0] oam_a, oam_a2;
  logic [7:0]  oam_din, oam_din2;
  logic        oam_wr, oam_wr2;
  logic        dma_active, dma_active2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int act_cnt, wr_cnt, rd_cnt;
  int act2_cnt, wr2_cnt, last_wr2_cyc;

  logic [15:0] exp_rd[$];
  logic [23:0] exp_wr[$];
  logic [7:0]  shadow[160];

  oam_dma dut (
    .clk(clk), .rst_n(rst_n), .mmio_a(mmio_a), .mmio_din(mmio_din), .mmio_wr(mmio_wr),
    .mmio_dout(mmio_dout), .bus_a(bus_a), .bus_rd(bus_rd), .bus_din(bus_din),
    .oam_a(oam_a), .oam_din(oam_din), .oam_wr(oam_wr), .dma_active(dma_active)
  );

  oam_dma #(.CYCLES_PER_BYTE(2), .START_DELAY(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .mmio_a(mmio_a), .mmio_din(mmio_din), .mmio_wr(mmio_wr2),
    .mmio_dout(mmio_dout2), .bus_a(bus_a2), .bus_rd(bus_rd2), .bus_din(bus_din2),
    .oam_a(oam_a2), .oam_din(oam_din2), .oam_wr(oam_wr2), .dma_active(dma_active2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory: page C0 holds i^5A, every other page additionally XORs (page-C0).
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [7:0] pg;
    pg = a[15:8] - 8'hC0;
    return a[7:0] ^ 8'h5A ^ pg;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [7:0] page);
    logic [7:0] src;
    src = (page >= 8'hE0) ? (page - 8'h20) : page;
    exp_rd.delete();
    exp_wr.delete();
    for (int i = 0; i < 160; i++) begin
      exp_rd.push_back({src, 8'(i)});
      exp_wr.push_back({16'hFE00 + 16'(i), mem_byte({src, 8'(i)})});
    end
  endtask

  task automatic monitor();
    logic [15:0] er;
    logic [23:0] ew;
    int idx;
    cyc++;
    if (dma_active) act_cnt++;
    if (dma_active2) act2_cnt++;
    if (!bus_rd) chk("bus_a_park", 32'(bus_a), 32'(16'hFFFF));
    if (!oam_wr) begin
      chk("oam_a_park", 32'(oam_a), 32'(16'hFFFF));
      chk("oam_din_park", 32'(oam_din), 32'h0);
    end
    if (bus_rd) begin
      rd_cnt++;
      chk("sb_rd_pending", 32'(exp_rd.size() != 0), 32'h1);
      if (exp_rd.size() != 0) begin
        er = exp_rd.pop_front();
        chk("sb_bus_a", 32'(bus_a), 32'(er));
      end
    end
    if (oam_wr) begin
      wr_cnt++;
      chk("oam_a_range", 32'(oam_a >= 16'hFE00 && oam_a <= 16'hFE9F), 32'h1);
      chk("sb_wr_pending", 32'(exp_wr.size() != 0), 32'h1);
      if (exp_wr.size() != 0) begin
        ew = exp_wr.pop_front();
        chk("sb_oam_wr", 32'({oam_a, oam_din}), 32'(ew));
      end
      idx = int'(oam_a) - 32'hFE00;
      if (idx >= 0 && idx < 160) shadow[idx] = oam_din;
    end
    if (oam_wr2) begin
      wr2_cnt++;
      if (last_wr2_cyc >= 0) chk("p2_wr_gap", 32'(cyc - last_wr2_cyc), 32'd2);
      last_wr2_cyc = cyc;
    end
  endtask

  // One clock: respond to the reads seen before the edge, then sample away from the edge.
  task automatic tick();
    logic rd1, rd2;
    logic [15:0] a1, a2;
    rd1 = bus_rd; a1 = bus_a; rd2 = bus_rd2; a2 = bus_a2;
    @(posedge clk);
    #1;
    bus_din  = rd1 ? mem_byte(a1) : 8'h00;
    bus_din2 = rd2 ? mem_byte(a2) : 8'h00;
    #1;
    monitor();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    mmio_a = a; mmio_din = d; mmio_wr = 1'b1;
    tick();
    mmio_wr = 1'b0; mmio_a = 16'h0000; mmio_din = 8'h00;
  endtask

  task automatic clr_counts();
    act_cnt = 0; wr_cnt = 0; rd_cnt = 0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (dma_active && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(dma_active), 32'h0);
  endtask

  task automatic read_ff46(input string tag, input logic [7:0] exp);
    mmio_a = 16'hFF46; mmio_wr = 1'b0;
    #1;
    chk(tag, 32'(mmio_dout), 32'(exp));
    mmio_a = 16'h0000;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; mmio_a = 16'h0000; mmio_din = 8'h00; mmio_wr = 1'b0; mmio_wr2 = 1'b0;
    bus_din = 8'h00; bus_din2 = 8'h00;
    act_cnt = 0; wr_cnt = 0; rd_cnt = 0; act2_cnt = 0; wr2_cnt = 0; last_wr2_cyc = -1;
    @(posedge clk); #2;
    tick(); tick();
    // Reset state
    chk("rst_dma_active", 32'(dma_active), 32'h0);
    chk("rst_bus_rd", 32'(bus_rd), 32'h0);
    chk("rst_oam_wr", 32'(oam_wr), 32'h0);
    chk("rst_bus_a", 32'(bus_a), 32'(16'hFFFF));
    chk("rst_oam_a", 32'(oam_a), 32'(16'hFFFF));
    read_ff46("rst_ff46", 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Writes to neighbouring registers do nothing
    clr_counts();
    do_write(16'hFF45, 8'hC0);
    do_write(16'hFF47, 8'hC0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nb_dma_active", 32'(dma_active), 32'h0);
    end
    chk("nb_act_cnt", 32'(act_cnt), 32'h0);
    chk("nb_rd_cnt", 32'(rd_cnt), 32'h0);
    chk("nb_wr_cnt", 32'(wr_cnt), 32'h0);
    read_ff46("nb_ff46", 8'h00);

    // Full transfer from C000
    clr_counts();
    start_xfer(8'hC0);
    do_write(16'hFF46, 8'hC0);
    wait_idle(1000, "c0_timeout");
    chk("c0_active_clocks", 32'(act_cnt), 32'd644);
    chk("c0_wr_cnt", 32'(wr_cnt), 32'd160);
    chk("c0_rd_cnt", 32'(rd_cnt), 32'd160);
    chk("c0_sb_empty", 32'(exp_wr.size()), 32'h0);
    for (int i = 0; i < 160; i++) chk("c0_oam", 32'(shadow[i]), 32'(8'(i) ^ 8'h5A));

    // Restart with C1 after the 50th OAM write
    clr_counts();
    start_xfer(8'hC0);
    do_write(16'hFF46, 8'hC0);
    n = 0;
    while (wr_cnt < 50 && n < 1000) begin tick(); n++; end
    chk("rs_reach50", 32'(wr_cnt), 32'd50);
    start_xfer(8'hC1);
    do_write(16'hFF46, 8'hC1);
    n = 1;
    while (!bus_rd && n < 50) begin
      tick();
      if (!bus_rd) n++;
    end
    chk("rs_delay", 32'(n), 32'd4);
    chk("rs_first_rd", 32'(bus_a), 32'(16'hC100));
    wait_idle(1000, "rs_timeout");
    chk("rs_wr_total", 32'(wr_cnt), 32'd210);
    for (int i = 0; i < 160; i++) chk("rs_oam", 32'(shadow[i]), 32'(8'(i) ^ 8'h5B));

    // Echo page E3 reads from C3xx
    clr_counts();
    start_xfer(8'hE3);
    do_write(16'hFF46, 8'hE3);
    wait_idle(1000, "e3_timeout");
    chk("e3_rd_cnt", 32'(rd_cnt), 32'd160);
    chk("e3_sb_empty", 32'(exp_rd.size()), 32'h0);
    read_ff46("e3_ff46", 8'hE3);

    // Fast variant: 2 clocks per byte, 1 delay clock
    act2_cnt = 0; wr2_cnt = 0; last_wr2_cyc = -1;
    mmio_a = 16'hFF46; mmio_din = 8'hC0; mmio_wr2 = 1'b1;
    tick();
    mmio_wr2 = 1'b0; mmio_a = 16'h0000;
    n = 0;
    while (dma_active2 && n < 1000) begin tick(); n++; end
    chk("p2_timeout", 32'(dma_active2), 32'h0);
    chk("p2_active_clocks", 32'(act2_cnt), 32'd321);
    chk("p2_wr_cnt", 32'(wr2_cnt), 32'd160);

    // Asynchronous reset mid-transfer
    clr_counts();
    start_xfer(8'hC0);
    do_write(16'hFF46, 8'hC0);
    n = 0;
    while (wr_cnt < 10 && n < 1000) begin tick(); n++; end
    chk("ar_reach10", 32'(oam_wr), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_oam_wr", 32'(oam_wr), 32'h0);
    chk("ar_bus_rd", 32'(bus_rd), 32'h0);
    chk("ar_dma_active", 32'(dma_active), 32'h0);
    chk("ar_oam_a", 32'(oam_a), 32'(16'hFFFF));
    exp_rd.delete();
    exp_wr.delete();
    @(posedge clk); #2;
    clr_counts();
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 700; i++) tick();
    chk("ar_no_writes", 32'(wr_cnt), 32'h0);
    chk("ar_no_active", 32'(act_cnt), 32'h0);
    read_ff46("ar_ff46", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
